// File: rtl/raggedstone_spinn_aer_if_button_debounce.sv
`default_nettype none
// ============================================================================
// Module  : raggedstone_spinn_aer_if_button_debounce
// Brief   : Per-button synchroniser + debounce FSM with press/release/long pulses.
// Revision: 1.0
// ============================================================================
module raggedstone_spinn_aer_if_button_debounce #(
  parameter int NUM_BTN      = 2,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 50000,
  parameter int LONG_CNT     = 2**24
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] i_btn_n,
  output logic [NUM_BTN-1:0] btn_n,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long
);

  localparam int DW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
  localparam int HW = (LONG_CNT > 1) ? $clog2(LONG_CNT) : 1;
  localparam logic [DW-1:0] C_DEB_LAST  = DW'(DEBOUNCE_CNT - 1);
  localparam logic [HW-1:0] C_HOLD_LAST = HW'(LONG_CNT - 1);

  typedef enum logic [1:0] {
    ST_RELEASED  = 2'd0,
    ST_PRESS_CHK = 2'd1,
    ST_PRESSED   = 2'd2,
    ST_REL_CHK   = 2'd3
  } state_e;

  for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_btn
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_s;
    state_e                 state_q;
    logic [DW-1:0]          dcnt_q;
    logic [HW-1:0]          hcnt_q;
    logic                   long_done_q;
    logic                   btn_n_q;
    logic                   press_q;
    logic                   release_q;
    logic                   long_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        sync_q <= '1;
      end else begin
        sync_q <= {sync_q[SYNC_STAGES-2:0], i_btn_n[gi]};
      end
    end

    assign sync_s = sync_q[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q     <= ST_RELEASED;
        dcnt_q      <= '0;
        hcnt_q      <= '0;
        long_done_q <= 1'b0;
        btn_n_q     <= 1'b1;
        press_q     <= 1'b0;
        release_q   <= 1'b0;
        long_q      <= 1'b0;
      end else begin
        press_q   <= 1'b0;
        release_q <= 1'b0;
        long_q    <= 1'b0;
        case (state_q)
          ST_RELEASED: begin
            if (!sync_s) begin
              state_q <= ST_PRESS_CHK;
              dcnt_q  <= '0;
            end
          end
          ST_PRESS_CHK: begin
            if (sync_s) begin
              state_q <= ST_RELEASED;
              dcnt_q  <= '0;
            end else if (dcnt_q == C_DEB_LAST) begin
              state_q     <= ST_PRESSED;
              btn_n_q     <= 1'b0;
              press_q     <= 1'b1;
              hcnt_q      <= '0;
              long_done_q <= 1'b0;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          ST_PRESSED: begin
            // hcnt saturates at its last value; the done flag limits long to one pulse
            if (sync_s) begin
              state_q <= ST_REL_CHK;
              dcnt_q  <= '0;
            end else if (hcnt_q != C_HOLD_LAST) begin
              hcnt_q <= hcnt_q + 1'b1;
            end else if (!long_done_q) begin
              long_q      <= 1'b1;
              long_done_q <= 1'b1;
            end
          end
          ST_REL_CHK: begin
            if (!sync_s) begin
              state_q <= ST_PRESSED;
              dcnt_q  <= '0;
            end else if (dcnt_q == C_DEB_LAST) begin
              state_q   <= ST_RELEASED;
              btn_n_q   <= 1'b1;
              release_q <= 1'b1;
            end else begin
              dcnt_q <= dcnt_q + 1'b1;
            end
          end
          default: begin
            state_q <= ST_RELEASED;
            btn_n_q <= 1'b1;
            dcnt_q  <= '0;
          end
        endcase
      end
    end

    assign btn_n[gi]       = btn_n_q;
    assign btn_press[gi]   = press_q;
    assign btn_release[gi] = release_q;
    assign btn_long[gi]    = long_q;
  end

endmodule
`default_nettype wire

// File: tb/tb_raggedstone_spinn_aer_if_button_debounce.sv
`default_nettype none
// ============================================================================
// Module  : tb_raggedstone_spinn_aer_if_button_debounce
// Brief   : Random bouncy stimulus checked against an event-level reference model.
// Revision: 1.0
// ============================================================================
module tb_raggedstone_spinn_aer_if_button_debounce;

  localparam int NB = 2;
  localparam int SS = 2;
  localparam int DB = 4;
  localparam int LC = 20;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [NB-1:0] raw = '0;
  logic [NB-1:0] btn_n;
  logic [NB-1:0] btn_press;
  logic [NB-1:0] btn_release;
  logic [NB-1:0] btn_long;

  raggedstone_spinn_aer_if_button_debounce #(
    .NUM_BTN      (NB),
    .SYNC_STAGES  (SS),
    .DEBOUNCE_CNT (DB),
    .LONG_CNT     (LC)
  ) u_dut (
    .clk         (clk),
    .rst         (rst),
    .i_btn_n     (raw),
    .btn_n       (btn_n),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: raw input is delayed SS samples, then a level change is
  // accepted once the delayed value disagrees with the level for DB+1 samples.
  bit            m_dly [NB][SS];
  bit [NB-1:0]   m_lvl;
  int            m_run [NB];
  int            m_hold[NB];
  bit            m_done[NB];
  bit [NB-1:0]   e_press, e_rel, e_long;
  int            n_long_seen = 0;
  int            n_press_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int b = 0; b < NB; b++) begin
      for (int i = 0; i < SS; i++) m_dly[b][i] = 1'b1;
      m_run[b]  = 0;
      m_hold[b] = 0;
      m_done[b] = 1'b0;
    end
    m_lvl   = '1;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
  endtask

  task automatic model_step();
    bit s;
    e_press = '0;
    e_rel   = '0;
    e_long  = '0;
    for (int b = 0; b < NB; b++) begin
      s = m_dly[b][SS-1];
      if (s != m_lvl[b]) begin
        m_run[b]++;
        if (m_run[b] == DB + 1) begin
          m_lvl[b] = s;
          m_run[b] = 0;
          if (!s) begin
            e_press[b] = 1'b1;
            m_hold[b]  = 0;
            m_done[b]  = 1'b0;
            n_press_seen++;
          end else begin
            e_rel[b] = 1'b1;
          end
        end
      end else begin
        // only uninterrupted held samples advance the long-press count
        if (!m_lvl[b] && m_run[b] == 0) begin
          m_hold[b]++;
          if (m_hold[b] == LC && !m_done[b]) begin
            e_long[b] = 1'b1;
            m_done[b] = 1'b1;
            n_long_seen++;
          end
        end
        m_run[b] = 0;
      end
      for (int i = SS - 1; i > 0; i--) m_dly[b][i] = m_dly[b][i-1];
      m_dly[b][0] = raw[b];
    end
  endtask

  task automatic compare_all(input string tag);
    check_eq({tag, ".btn_n"},       32'(btn_n),       32'(m_lvl));
    check_eq({tag, ".btn_press"},   32'(btn_press),   32'(e_press));
    check_eq({tag, ".btn_release"}, 32'(btn_release), 32'(e_rel));
    check_eq({tag, ".btn_long"},    32'(btn_long),    32'(e_long));
  endtask

  int          g_rem[NB];
  bit [NB-1:0] g_lvl;

  function automatic bit [NB-1:0] gen_raw(input int cyc);
    bit [NB-1:0] v;
    for (int b = 0; b < NB; b++) begin
      if (g_rem[b] == 0) begin
        g_lvl[b] = ~g_lvl[b];
        g_rem[b] = ($urandom_range(0, 3) == 0) ? $urandom_range(22, 45) : $urandom_range(1, 7);
      end
      g_rem[b]--;
    end
    v = g_lvl;
    if (cyc >= 780 && cyc < 800)  v = 2'b11;
    if (cyc >= 800 && cyc < 840)  v = 2'b00;
    if (cyc >= 1480 && cyc < 1500) v[0] = 1'b1;
    if (cyc >= 1500 && cyc < 1540) v[0] = 1'b0;
    return v;
  endfunction

  initial begin
    g_lvl = '1;
    for (int b = 0; b < NB; b++) g_rem[b] = 0;
    raw = 2'b00;
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all("reset_hold");
    rst = 1'b1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk);
      if (rst) model_step();
      else     model_reset();
      if (cyc == 1516) begin
        #2 rst = 1'b0;
        model_reset();
        #1 compare_all("async_rst");
      end
      @(negedge clk);
      compare_all("cycle");
      if (cyc == 1519) rst = 1'b1;
      raw = gen_raw(cyc);
    end
    check_eq("long_seen",  32'(n_long_seen > 0),  32'd1);
    check_eq("press_seen", 32'(n_press_seen > 4), 32'd1);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
